risc_multicycle_controller: RTL

Parametrised multi-cycle RV32I control unit. It replaces single-cycle combinational decode with a Moore/Mealy FSM that sequences fetch, decode, execute, memory and writeback over several clocks, sharing one memory port and one ALU. It sits between the instruction register and the datapath muxes and enables. It adds:

- memory wait handshaking,
- signed branches (blt/bge), lui, sra/xor/slt/sltu,
- an illegal-instruction trap,
- a retired-instruction counter.

---
 rtl/risc_pkg.sv | 78 +++++++
 rtl/risc_multicycle_controller_alu_decoder.sv | 37 +++
 rtl/risc_multicycle_controller.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/risc_pkg.sv
// Shared constants for the multi-cycle RV32I controller: FSM state codes,
// ALU operation codes, datapath mux encodings and the opcodes it decodes.
package risc_pkg;

    // FSM state codes; kept as plain constants so older tools and netlists can use them
    typedef logic [3:0] state_t;

    localparam state_t S_IDLE    = 4'd0;
    localparam state_t S_FETCH   = 4'd1;
    localparam state_t S_DECODE  = 4'd2;
    localparam state_t S_MEM_ADR = 4'd3;
    localparam state_t S_MEM_RD  = 4'd4;
    localparam state_t S_MEM_WB  = 4'd5;
    localparam state_t S_MEM_WR  = 4'd6;
    localparam state_t S_EXEC_R  = 4'd7;
    localparam state_t S_EXEC_I  = 4'd8;
    localparam state_t S_ALU_WB  = 4'd9;
    localparam state_t S_BRANCH  = 4'd10;
    localparam state_t S_JAL     = 4'd11;
    localparam state_t S_LUI     = 4'd12;
    localparam state_t S_TRAP    = 4'd13;

    // ALU operation codes (4 bits; zero-extended when the port is wider)
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_SLL  = 4'd4;
    localparam logic [3:0] ALU_SRL  = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    // ALU A-operand select
    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;
    localparam logic [1:0] SRC_A_ZERO   = 2'b11;

    // ALU B-operand select
    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    // Immediate formats
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Register-file write-back source
    localparam logic [1:0] RES_ALU     = 2'b00;
    localparam logic [1:0] RES_MEM     = 2'b01;
    localparam logic [1:0] RES_ALU_OUT = 2'b10;

    // Opcodes understood by the controller
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // Branch funct3 codes that are implemented
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    // True when funct3 names a branch this controller implements
    function automatic logic branch_f3_legal(input logic [2:0] f3);
        return (f3 == F3_BEQ) || (f3 == F3_BNE) || (f3 == F3_BLT) || (f3 == F3_BGE);
    endfunction

endpackage

// File: rtl/risc_multicycle_controller_alu_decoder.sv
// Combinational ALU-operation decoder for R-type and I-type arithmetic.
// funct7_b5 selects SUB only for R-type; for shifts-right it selects SRA in both forms.
module alu_decoder
    import risc_pkg::*;
#(
    parameter int ALU_OP_W = 4
) (
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic                funct7_b5,
    output logic [ALU_OP_W-1:0] alu_op
);

    logic       is_r_type;
    logic [3:0] op_sel;

    assign is_r_type = (opcode == OP_R);

    // Map funct3 (plus funct7 bit 5 where it matters) to an ALU operation
    always_comb begin
        op_sel = ALU_ADD;
        case (funct3)
            3'b000:  op_sel = (is_r_type && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op_sel = ALU_SLL;
            3'b010:  op_sel = ALU_SLT;
            3'b011:  op_sel = ALU_SLTU;
            3'b100:  op_sel = ALU_XOR;
            3'b101:  op_sel = funct7_b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op_sel = ALU_OR;
            3'b111:  op_sel = ALU_AND;
            default: op_sel = ALU_ADD;
        endcase
    end

    assign alu_op = ALU_OP_W'(op_sel);

endmodule

// File: rtl/risc_multicycle_controller.sv
// Multi-cycle RV32I control unit: sequences fetch, decode, execute, memory and
// write-back over several clocks, sharing one memory port and one ALU.
// Outputs are decoded from the state; only BRANCH's pc_write looks at zero/lt.
module risc_multicycle_controller
    import risc_pkg::*;
#(
    parameter int ALU_OP_W = 4,
    parameter int CNT_W    = 32,
    parameter int MEM_WAIT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic                funct7_b5,
    input  logic                zero,
    input  logic                lt,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                ir_write,
    output logic                reg_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                adr_src,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [2:0]          imm_src,
    output logic [1:0]          result_src,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                illegal,
    output logic [CNT_W-1:0]    instr_retired
);

    state_t              state;
    state_t              next_state;
    logic                mem_rdy;
    logic                branch_legal;
    logic                branch_taken;
    logic                retire;
    logic [ALU_OP_W-1:0] dec_alu_op;

    // With MEM_WAIT = 0 the memory is assumed to complete every access in one cycle
    assign mem_rdy = (MEM_WAIT != 0) ? mem_ready : 1'b1;

    assign branch_legal = branch_f3_legal(funct3);

    // Branch condition from the ALU flags; illegal funct3 never redirects the PC
    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            F3_BEQ:  branch_taken = zero;
            F3_BNE:  branch_taken = ~zero;
            F3_BLT:  branch_taken = lt;
            F3_BGE:  branch_taken = ~lt;
            default: branch_taken = 1'b0;
        endcase
    end

    alu_decoder #(
        .ALU_OP_W (ALU_OP_W)
    ) u_alu_decoder (
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7_b5 (funct7_b5),
        .alu_op    (dec_alu_op)
    );

    // State register; reset parks the machine in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state sequencing, including the memory wait holds and the sticky trap
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    next_state = S_FETCH;
            S_FETCH:   next_state = mem_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: next_state = S_MEM_ADR;
                    OP_R:              next_state = S_EXEC_R;
                    OP_I:              next_state = S_EXEC_I;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_JAL:            next_state = S_JAL;
                    OP_LUI:            next_state = S_LUI;
                    default:           next_state = S_TRAP;
                endcase
            end
            S_MEM_ADR: next_state = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:  next_state = mem_rdy ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:  next_state = S_FETCH;
            S_MEM_WR:  next_state = mem_rdy ? S_FETCH : S_MEM_WR;
            S_EXEC_R:  next_state = S_ALU_WB;
            S_EXEC_I:  next_state = S_ALU_WB;
            S_ALU_WB:  next_state = S_FETCH;
            S_BRANCH:  next_state = branch_legal ? S_FETCH : S_TRAP;
            S_JAL:     next_state = S_ALU_WB;
            S_LUI:     next_state = S_ALU_WB;
            S_TRAP:    next_state = S_TRAP;
            default:   next_state = S_IDLE;
        endcase
    end

    // Datapath control decode; everything not named in a state stays 0 / ADD
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        imm_src    = IMM_I;
        result_src = RES_ALU;
        alu_op     = ALU_OP_W'(ALU_ADD);
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                adr_src   = 1'b0;
                alu_src_a = SRC_A_PC;
                alu_src_b = SRC_B_FOUR;
                ir_write  = mem_rdy;
                pc_write  = mem_rdy;
            end
            S_DECODE: begin
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
                imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
            end
            S_MEM_ADR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                imm_src   = (opcode == OP_LOAD) ? IMM_I : IMM_S;
            end
            S_MEM_RD: begin
                adr_src    = 1'b1;
                mem_read   = 1'b1;
                result_src = RES_ALU_OUT;
            end
            S_MEM_WB: begin
                result_src = RES_MEM;
                reg_write  = 1'b1;
            end
            S_MEM_WR: begin
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                result_src = RES_ALU_OUT;
            end
            S_EXEC_R: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_RS2;
                alu_op    = dec_alu_op;
            end
            S_EXEC_I: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                imm_src   = IMM_I;
                alu_op    = dec_alu_op;
            end
            S_ALU_WB: begin
                result_src = RES_ALU_OUT;
                reg_write  = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_RS2;
                alu_op     = ALU_OP_W'(ALU_SUB);
                result_src = RES_ALU_OUT;
                pc_write   = branch_legal && branch_taken;
            end
            S_JAL: begin
                alu_src_a  = SRC_A_OLD_PC;
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALU_OUT;
                pc_write   = 1'b1;
            end
            S_LUI: begin
                alu_src_a = SRC_A_ZERO;
                alu_src_b = SRC_B_IMM;
                imm_src   = IMM_U;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                illegal = 1'b0;
            end
        endcase
    end

    // An instruction retires when its final state hands back to FETCH
    assign retire = (state == S_MEM_WB)
                 || ((state == S_MEM_WR) && mem_rdy)
                 || (state == S_ALU_WB)
                 || ((state == S_BRANCH) && branch_legal);

    // Retired-instruction counter, wrapping naturally at 2^CNT_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_retired <= '0;
        end else if (retire) begin
            instr_retired <= instr_retired + CNT_W'(1);
        end
    end

endmodule
